// File: rtl/axi_rd_arbiter_nm.sv
// rtl/axi_rd_arbiter_nm.sv - N-master AXI read arbiter with one read burst outstanding
// Define AXI_RD_ARB_RR_EN for round-robin grant; the default build uses fixed priority (lowest index wins).
module axi_rd_arbiter_nm #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SID_W      = ID_W + IDX_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_arvalid,
    output logic [NUM_MASTERS-1:0]        m_arready,
    input  logic [NUM_MASTERS*ID_W-1:0]   m_arid,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
    input  logic [NUM_MASTERS*4-1:0]      m_arlen,
    input  logic [NUM_MASTERS*3-1:0]      m_arsize,
    input  logic [NUM_MASTERS*2-1:0]      m_arburst,
    output logic [NUM_MASTERS-1:0]        m_rvalid,
    input  logic [NUM_MASTERS-1:0]        m_rready,
    output logic [ID_W-1:0]               m_rid,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [1:0]                    m_rresp,
    output logic                          m_rlast,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    output logic [SID_W-1:0]              s_arid,
    output logic [ADDR_W-1:0]             s_araddr,
    output logic [3:0]                    s_arlen,
    output logic [2:0]                    s_arsize,
    output logic [1:0]                    s_arburst,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    input  logic [SID_W-1:0]              s_rid,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic                          s_rlast
);

    localparam int CW = IDX_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   owner_q;
    logic [ID_W-1:0]    ar_id_q;
    logic [ADDR_W-1:0]  ar_addr_q;
    logic [3:0]         ar_len_q;
    logic [2:0]         ar_size_q;
    logic [1:0]         ar_burst_q;

    logic [IDX_W-1:0]   grant;
    logic               any_req;
    logic               unused_rid_hi;

    assign any_req       = |m_arvalid;
    assign unused_rid_hi = ^s_rid[SID_W-1:ID_W];

`ifdef AXI_RD_ARB_RR_EN
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] rr_d;
    logic [CW-1:0]    rr_idx;
    logic             rr_found;

    // Scan upward from the pointer with wrap; first requester found wins.
    always_comb begin
        grant    = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            rr_idx = {1'b0, rr_q} + CW'(k);
            if (rr_idx >= CW'(NUM_MASTERS)) begin
                rr_idx = rr_idx - CW'(NUM_MASTERS);
            end
            if (!rr_found && m_arvalid[rr_idx[IDX_W-1:0]]) begin
                grant    = rr_idx[IDX_W-1:0];
                rr_found = 1'b1;
            end
        end
    end

    assign rr_d = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);
`else
    always_comb begin
        grant = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_arvalid[i]) begin
                grant = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        m_arready = '0;
        if (!rst && state_q == ST_IDLE && any_req) begin
            m_arready[grant] = 1'b1;
        end
    end

    // R routing keys off the registered owner only; RID upper bits are ignored.
    always_comb begin
        m_rvalid = '0;
        if (!rst && state_q == ST_DATA) begin
            m_rvalid[owner_q] = s_rvalid;
        end
    end

    assign s_rready  = !rst && (state_q == ST_DATA) && m_rready[owner_q];
    assign m_rid     = s_rid[ID_W-1:0];
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rlast   = s_rlast;

    assign s_arvalid = !rst && (state_q == ST_ADDR);
    assign s_arid    = {owner_q, ar_id_q};
    assign s_araddr  = ar_addr_q;
    assign s_arlen   = ar_len_q;
    assign s_arsize  = ar_size_q;
    assign s_arburst = ar_burst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
`ifdef AXI_RD_ARB_RR_EN
            rr_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        ar_id_q    <= m_arid[grant*ID_W +: ID_W];
                        ar_addr_q  <= m_araddr[grant*ADDR_W +: ADDR_W];
                        ar_len_q   <= m_arlen[grant*4 +: 4];
                        ar_size_q  <= m_arsize[grant*3 +: 3];
                        ar_burst_q <= m_arburst[grant*2 +: 2];
                        owner_q    <= grant;
                        state_q    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (s_arready) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (s_rvalid && s_rready && s_rlast) begin
                        state_q <= ST_IDLE;
`ifdef AXI_RD_ARB_RR_EN
                        rr_q    <= rr_d;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter_nm.sv
// tb/tb_axi_rd_arbiter_nm.sv - self-checking bench for axi_rd_arbiter_nm (three masters)
// Transaction-level model checks every cycle; directed tests pin key values with literals.
module tb_axi_rd_arbiter_nm;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int XW = 2;
    localparam int SW = IW + XW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM-1:0]     m_arvalid, m_arready, m_rvalid, m_rready;
    logic [NM*IW-1:0]  m_arid;
    logic [NM*AW-1:0]  m_araddr;
    logic [NM*4-1:0]   m_arlen;
    logic [NM*3-1:0]   m_arsize;
    logic [NM*2-1:0]   m_arburst;
    logic [IW-1:0]     m_rid;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              s_arvalid, s_arready;
    logic [SW-1:0]     s_arid;
    logic [AW-1:0]     s_araddr;
    logic [3:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic              s_rvalid, s_rready;
    logic [SW-1:0]     s_rid;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;

    int tests = 0;
    int fails = 0;

    axi_rd_arbiter_nm #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // m_rready is owned by this process: a steady level or a per-cycle toggle.
    bit            rr_toggle;
    logic [NM-1:0] rr_level;
    initial begin
        m_rready = '0;
        forever begin
            @(posedge clk);
            #1;
            m_rready = rr_toggle ? ~m_rready : rr_level;
        end
    end

    // Model: phase 0 = waiting for a request, 1 = address offered, 2 = beats returning.
    int             ph, owner, ptr, g, idx;
    logic [IW-1:0]  c_id;
    logic [AW-1:0]  c_addr;
    logic [3:0]     c_len;
    logic [2:0]     c_size;
    logic [1:0]     c_burst;
    logic [NM-1:0]  e_arready, e_rvalid;
    logic           e_srready, e_sarvalid;
    int             grant_log[$];
    logic [DW-1:0]  rx_data[$];
    int             rx_owner[$];

    initial begin
        ph = 0; owner = 0; ptr = 0;
        c_id = '0; c_addr = '0; c_len = '0; c_size = '0; c_burst = '0;
        forever begin
            @(negedge clk);
            e_arready = '0; e_rvalid = '0; e_srready = 1'b0; e_sarvalid = 1'b0; g = -1;
            if (!rst) begin
                if (ph == 0 && m_arvalid != '0) begin
                    for (int k = 0; k < NM; k++) begin
                        idx = (ptr + k) % NM;
                        if (g < 0 && m_arvalid[idx]) g = idx;
                    end
                    e_arready[g] = 1'b1;
                end
                if (ph == 1) e_sarvalid = 1'b1;
                if (ph == 2) begin
                    e_rvalid[owner] = s_rvalid;
                    e_srready       = m_rready[owner];
                end
            end
            check("m_arready", m_arready, e_arready);
            check("s_arvalid", s_arvalid, e_sarvalid);
            check("m_rvalid", m_rvalid, e_rvalid);
            check("s_rready", s_rready, e_srready);
            if (e_sarvalid) begin
                check("s_arid", s_arid, {owner[XW-1:0], c_id});
                check("s_araddr", s_araddr, c_addr);
                check("s_arlen", s_arlen, c_len);
                check("s_arsize", s_arsize, c_size);
                check("s_arburst", s_arburst, c_burst);
            end
            if (e_rvalid != '0) begin
                check("m_rid", m_rid, s_rid[IW-1:0]);
                check("m_rdata", m_rdata, s_rdata);
                check("m_rresp", m_rresp, s_rresp);
                check("m_rlast", m_rlast, s_rlast);
            end
            if (rst) begin
                ph = 0; owner = 0; ptr = 0;
            end else begin
                case (ph)
                    0: if (g >= 0) begin
                        c_id    = m_arid[g*IW +: IW];
                        c_addr  = m_araddr[g*AW +: AW];
                        c_len   = m_arlen[g*4 +: 4];
                        c_size  = m_arsize[g*3 +: 3];
                        c_burst = m_arburst[g*2 +: 2];
                        owner   = g;
                        ph      = 1;
                        grant_log.push_back(g);
                    end
                    1: if (s_arready) ph = 2;
                    2: if (s_rvalid && e_srready) begin
                        rx_data.push_back(s_rdata);
                        rx_owner.push_back(owner);
                        if (s_rlast) begin
                            ph = 0;
`ifdef AXI_RD_ARB_RR_EN
                            ptr = (owner + 1) % NM;
`endif
                        end
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [3:0] len);
        m_arid[m*IW +: IW]   = id;
        m_araddr[m*AW +: AW] = addr;
        m_arlen[m*4 +: 4]    = len;
        m_arsize[m*3 +: 3]   = 3'd2;
        m_arburst[m*2 +: 2]  = 2'b01;
        m_arvalid[m]         = 1'b1;
    endtask

    task automatic wait_grant(input int m);
        int n;
        n = 0;
        @(negedge clk);
        while (!m_arready[m] && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("grant_wait", m_arready[m], 1'b1);
        tick;
        m_arvalid[m] = 1'b0;
    endtask

    task automatic slave_accept;
        int n;
        n = 0;
        @(negedge clk);
        while (!s_arvalid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("arvalid_wait", s_arvalid, 1'b1);
        tick;
        s_arready = 1'b1;
        tick;
        s_arready = 1'b0;
    endtask

    task automatic slave_burst(input int beats, input logic [SW-1:0] rid, input logic [DW-1:0] base);
        for (int b = 0; b < beats; b++) begin
            int n;
            n        = 0;
            s_rvalid = 1'b1;
            s_rid    = rid;
            s_rdata  = base + DW'(b);
            s_rresp  = 2'b00;
            s_rlast  = (b == beats - 1);
            @(negedge clk);
            while (!s_rready && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("rready_wait", s_rready, 1'b1);
            tick;
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    int exp_g[4];

    initial begin
        rst = 1'b1;
        m_arvalid = '0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
        rr_toggle = 1'b0; rr_level = '1;
`ifdef AXI_RD_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        repeat (3) tick;
        @(negedge clk);
        check("reset_arready", m_arready, 3'b000);
        check("reset_sarvalid", s_arvalid, 1'b0);
        check("reset_rvalid", m_rvalid, 3'b000);
        check("reset_srready", s_rready, 1'b0);
        tick;
        rst = 1'b0;

        // single read from m0
        rx_data.delete(); rx_owner.delete();
        set_ar(0, 4'h5, 32'h100, 4'd0);
        @(negedge clk);
        check("single_arready", m_arready, 3'b001);
        tick;
        m_arvalid[0] = 1'b0;
        @(negedge clk);
        check("single_sarvalid", s_arvalid, 1'b1);
        check("single_arid", s_arid, 6'h05);
        check("single_araddr", s_araddr, 32'h100);
        tick;
        s_arready = 1'b1;
        tick;
        s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF; s_rid = 6'h05; s_rlast = 1'b1; s_rresp = 2'b00;
        @(negedge clk);
        check("single_rvalid", m_rvalid, 3'b001);
        check("single_rid", m_rid, 4'h5);
        check("single_rdata", m_rdata, 32'hDEADBEEF);
        check("single_rlast", m_rlast, 1'b1);
        tick;
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge clk);
        check("single_idle_srready", s_rready, 1'b0);
        check("single_beats", rx_data.size(), 1);

        // four-beat burst with toggling R backpressure
        rx_data.delete(); rx_owner.delete();
        tick;
        set_ar(0, 4'hA, 32'h300, 4'd3);
        wait_grant(0);
        slave_accept();
        rr_toggle = 1'b1;
        slave_burst(4, 6'h0A, 32'hA0);
        rr_toggle = 1'b0;
        rr_level  = '1;
        @(negedge clk);
        check("burst_beats", rx_data.size(), 4);
        for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
            check("burst_data", rx_data[i], 32'hA0 + 32'(i));
            check("burst_owner", rx_owner[i], 0);
        end
        check("burst_idle_srready", s_rready, 1'b0);

        // slave AR stall with another master waiting
        tick;
        set_ar(0, 4'h3, 32'h200, 4'd0);
        wait_grant(0);
        set_ar(1, 4'h7, 32'h400, 4'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_sarvalid", s_arvalid, 1'b1);
            check("stall_araddr", s_araddr, 32'h200);
            check("stall_arid", s_arid, 6'h03);
            check("stall_arready", m_arready, 3'b000);
            tick;
        end
        s_arready = 1'b1;
        tick;
        s_arready = 1'b0;
        slave_burst(1, 6'h03, 32'h11);
        wait_grant(1);
        slave_accept();
        slave_burst(1, 6'h17, 32'h22);

        // reset in the middle of a four-beat burst
        set_ar(0, 4'h9, 32'h500, 4'd3);
        wait_grant(0);
        slave_accept();
        for (int b = 0; b < 2; b++) begin
            s_rvalid = 1'b1; s_rdata = 32'h60 + 32'(b); s_rid = 6'h09; s_rlast = 1'b0;
            @(negedge clk);
            check("midrst_beat_rready", s_rready, 1'b1);
            tick;
        end
        s_rdata = 32'h62;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rvalid", m_rvalid, 3'b000);
        check("midrst_srready", s_rready, 1'b0);
        tick;
        rst = 1'b0;
        set_ar(1, 4'h6, 32'h600, 4'd0);
        @(negedge clk);
        check("postrst_srready", s_rready, 1'b0);
        check("postrst_rvalid", m_rvalid, 3'b000);
        check("postrst_arready", m_arready, 3'b010);
        tick;
        m_arvalid[1] = 1'b0;
        s_rvalid = 1'b0;
        slave_accept();
        slave_burst(1, 6'h16, 32'h33);

        // third master: owner index 2 prepended to ARID
        rx_data.delete(); rx_owner.delete();
        set_ar(2, 4'hC, 32'h700, 4'd0);
        wait_grant(2);
        @(negedge clk);
        check("m2_arid", s_arid, 6'h2C);
        slave_accept();
        slave_burst(1, 6'h2C, 32'h44);
        check("m2_owner", (rx_owner.size() > 0) ? rx_owner[0] : -1, 2);

        // m0 and m1 requesting continuously
        grant_log.delete();
        set_ar(0, 4'h1, 32'h800, 4'd0);
        set_ar(1, 4'h2, 32'h900, 4'd0);
        for (int t = 0; t < 4; t++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (m_arready == '0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("contend_grant_wait", (m_arready != '0), 1'b1);
            tick;
            slave_accept();
            slave_burst(1, 6'h00, 32'h50 + 32'(t));
        end
        m_arvalid = '0;
        check("contend_count", grant_log.size(), 4);
        for (int t = 0; t < 4 && t < grant_log.size(); t++) begin
            check("contend_order", grant_log[t], exp_g[t]);
        end

        repeat (3) tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
